// File: rtl/axi_lite_slave_arbiter.sv
// Per-peripheral AXI4-Lite arbiter: independent round-robin write and read grants,
// each held from address phase to response. Optional watchdog: AXI_ARB_TIMEOUT_EN.
module axi_lite_slave_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_MASTERS-1:0] wr_req,
  input  logic [NUM_MASTERS-1:0] rd_req,
  input  logic                   aw_hs,
  input  logic                   w_hs,
  input  logic                   b_hs,
  input  logic                   ar_hs,
  input  logic                   r_hs,
  output logic [NUM_MASTERS-1:0] wr_gnt,
  output logic [IDXW-1:0]        wr_gnt_idx,
  output logic                   wr_busy,
  output logic [NUM_MASTERS-1:0] rd_gnt,
  output logic [IDXW-1:0]        rd_gnt_idx,
  output logic                   rd_busy,
  output logic                   timeout_err,
  output logic [1:0]             wr_state_dbg,
  output logic [1:0]             rd_state_dbg
);

  // Handshake inputs are single-cycle transfer strobes (VALID && READY already
  // combined by the crossbar); each is honoured only in the state that expects it.
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;
  logic [IDXW-1:0] w_idx, w_idx_n, w_ptr, w_ptr_n;
  logic [IDXW-1:0] r_idx, r_idx_n, r_ptr, r_ptr_n;
  logic aw_done, aw_done_n, w_done, w_done_n;
  logic [IDXW:0] w_pick, r_pick;

  // Returns {found, index}; descending scan so the lowest offset from ptr wins.
  function automatic logic [IDXW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IDXW-1:0] ptr);
    logic [IDXW:0] res;
    int j;
    res = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_MASTERS;
      if (req[j]) res = {1'b1, IDXW'(j)};
    end
    return res;
  endfunction

  function automatic logic [IDXW-1:0] ptr_after(input logic [IDXW-1:0] winner);
    return (winner == IDXW'(NUM_MASTERS - 1)) ? '0 : winner + IDXW'(1);
  endfunction

  assign w_pick = rr_pick(wr_req, w_ptr);
  assign r_pick = rr_pick(rd_req, r_ptr);

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNTW-1:0] w_cnt, w_cnt_n, r_cnt, r_cnt_n;
  logic w_to, r_to, to_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      w_idx   <= '0;
      r_idx   <= '0;
      w_ptr   <= '0;
      r_ptr   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
      w_cnt   <= '0;
      r_cnt   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
      w_idx   <= w_idx_n;
      r_idx   <= r_idx_n;
      w_ptr   <= w_ptr_n;
      r_ptr   <= r_ptr_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
`ifdef AXI_ARB_TIMEOUT_EN
      w_cnt   <= w_cnt_n;
      r_cnt   <= r_cnt_n;
      to_q    <= w_to | r_to;
`endif
    end
  end

  // Next-state logic for both channels
  always_comb begin
    w_state_n = w_state;
    w_idx_n   = w_idx;
    w_ptr_n   = w_ptr;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    unique case (w_state)
      W_IDLE: if (w_pick[IDXW]) begin
        w_idx_n   = w_pick[IDXW-1:0];
        w_ptr_n   = ptr_after(w_pick[IDXW-1:0]);
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        w_state_n = W_ADDR;
      end
      W_ADDR: begin
        aw_done_n = aw_done | aw_hs;
        w_done_n  = w_done | w_hs;
        if ((aw_done | aw_hs) && (w_done | w_hs)) w_state_n = W_RESP;
      end
      W_RESP: if (b_hs) begin
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
        w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase

    r_state_n = r_state;
    r_idx_n   = r_idx;
    r_ptr_n   = r_ptr;
    unique case (r_state)
      R_IDLE: if (r_pick[IDXW]) begin
        r_idx_n   = r_pick[IDXW-1:0];
        r_ptr_n   = ptr_after(r_pick[IDXW-1:0]);
        r_state_n = R_ADDR;
      end
      R_ADDR:  if (ar_hs) r_state_n = R_DATA;
      R_DATA:  if (r_hs) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase

`ifdef AXI_ARB_TIMEOUT_EN
    // A completing response in the expiry cycle wins over the watchdog.
    w_cnt_n = (w_state == W_IDLE) ? '0 : w_cnt + CNTW'(1);
    r_cnt_n = (r_state == R_IDLE) ? '0 : r_cnt + CNTW'(1);
    w_to = (w_state != W_IDLE) && (w_cnt == CNTW'(TIMEOUT_CYCLES - 1)) &&
           !((w_state == W_RESP) && b_hs);
    r_to = (r_state != R_IDLE) && (r_cnt == CNTW'(TIMEOUT_CYCLES - 1)) &&
           !((r_state == R_DATA) && r_hs);
    if (w_to) begin
      w_state_n = W_IDLE;
      aw_done_n = 1'b0;
      w_done_n  = 1'b0;
    end
    if (r_to) r_state_n = R_IDLE;
`endif
  end

  // Outputs
  always_comb begin
    wr_busy    = (w_state != W_IDLE);
    rd_busy    = (r_state != R_IDLE);
    wr_gnt     = '0;
    rd_gnt     = '0;
    wr_gnt_idx = '0;
    rd_gnt_idx = '0;
    if (wr_busy) begin
      wr_gnt[w_idx] = 1'b1;
      wr_gnt_idx    = w_idx;
    end
    if (rd_busy) begin
      rd_gnt[r_idx] = 1'b1;
      rd_gnt_idx    = r_idx;
    end
  end

  assign wr_state_dbg = w_state;
  assign rd_state_dbg = r_state;
`ifdef AXI_ARB_TIMEOUT_EN
  assign timeout_err = to_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_lite_slave_arbiter.sv
// Directed self-checking bench for axi_lite_slave_arbiter with two masters.
module tb_axi_lite_slave_arbiter;
  localparam int N = 2;

  logic aclk, aresetn;
  logic [N-1:0] wr_req, rd_req;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [N-1:0] wr_gnt, rd_gnt;
  logic [0:0] wr_gnt_idx, rd_gnt_idx;
  logic wr_busy, rd_busy, timeout_err;
  logic [1:0] wr_state_dbg, rd_state_dbg;

  int checks = 0;
  int errors = 0;

  axi_lite_slave_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wr_req(wr_req), .rd_req(rd_req),
    .aw_hs(aw_hs), .w_hs(w_hs), .b_hs(b_hs), .ar_hs(ar_hs), .r_hs(r_hs),
    .wr_gnt(wr_gnt), .wr_gnt_idx(wr_gnt_idx), .wr_busy(wr_busy),
    .rd_gnt(rd_gnt), .rd_gnt_idx(rd_gnt_idx), .rd_busy(rd_busy),
    .timeout_err(timeout_err),
    .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic chk_wr(input string tag, input logic [1:0] gnt, input logic idx,
                        input logic busy, input logic [1:0] st);
    check({tag, ".wr_gnt"}, 32'(wr_gnt), 32'(gnt));
    check({tag, ".wr_idx"}, 32'(wr_gnt_idx), 32'(idx));
    check({tag, ".wr_busy"}, 32'(wr_busy), 32'(busy));
    check({tag, ".wr_st"}, 32'(wr_state_dbg), 32'(st));
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] gnt, input logic idx,
                        input logic busy, input logic [1:0] st);
    check({tag, ".rd_gnt"}, 32'(rd_gnt), 32'(gnt));
    check({tag, ".rd_idx"}, 32'(rd_gnt_idx), 32'(idx));
    check({tag, ".rd_busy"}, 32'(rd_busy), 32'(busy));
    check({tag, ".rd_st"}, 32'(rd_state_dbg), 32'(st));
  endtask

  // One full write with wr_req held: grant, AW+W together, B; ends in the bubble cycle.
  task automatic wr_txn(input string tag, input logic [1:0] exp_gnt, input logic exp_idx);
    tick();
    chk_wr({tag, ".gnt"}, exp_gnt, exp_idx, 1'b1, 2'd1);
    aw_hs = 1'b1; w_hs = 1'b1;
    tick();
    aw_hs = 1'b0; w_hs = 1'b0;
    chk_wr({tag, ".resp"}, exp_gnt, exp_idx, 1'b1, 2'd2);
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    chk_wr({tag, ".bubble"}, 2'b00, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    aresetn = 1'b0;
    wr_req = '0; rd_req = '0;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    @(negedge aclk);
    @(negedge aclk);
    chk_wr("reset", 2'b00, 1'b0, 1'b0, 2'd0);
    chk_rd("reset", 2'b00, 1'b0, 1'b0, 2'd0);
    check("reset.timeout_err", 32'(timeout_err), 32'd0);
    aresetn = 1'b1;
    tick();

    // Single write from M0, AW and W together, B two cycles later
    wr_req = 2'b01;
    tick();
    chk_wr("t1.gnt", 2'b01, 1'b0, 1'b1, 2'd1);
    aw_hs = 1'b1; w_hs = 1'b1;
    tick();
    aw_hs = 1'b0; w_hs = 1'b0;
    chk_wr("t1.resp", 2'b01, 1'b0, 1'b1, 2'd2);
    tick();
    chk_wr("t1.wait", 2'b01, 1'b0, 1'b1, 2'd2);
    b_hs = 1'b1; wr_req = 2'b00;
    tick();
    b_hs = 1'b0;
    chk_wr("t1.done", 2'b00, 1'b0, 1'b0, 2'd0);

    // Both requesting: pointer sits at 1 after the M0 write, so M1 goes first
    wr_req = 2'b11;
    wr_txn("t2a", 2'b10, 1'b1);
    wr_txn("t2b", 2'b01, 1'b0);
    wr_txn("t2c", 2'b10, 1'b1);
    wr_txn("t2d", 2'b01, 1'b0);
    wr_req = 2'b00;
    tick();

    // W before AW, early B ignored
    wr_req = 2'b01;
    tick();
    chk_wr("t3.gnt", 2'b01, 1'b0, 1'b1, 2'd1);
    wr_req = 2'b00;
    tick();
    w_hs = 1'b1;
    tick();
    w_hs = 1'b0;
    check("t3.after_w", 32'(wr_state_dbg), 32'd1);
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    chk_wr("t3.early_b", 2'b01, 1'b0, 1'b1, 2'd1);
    aw_hs = 1'b1;
    tick();
    aw_hs = 1'b0;
    check("t3.after_aw", 32'(wr_state_dbg), 32'd2);
    tick();
    check("t3.hold", 32'(wr_state_dbg), 32'd2);
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    chk_wr("t3.done", 2'b00, 1'b0, 1'b0, 2'd0);

    // Independent write and read grants
    wr_req = 2'b01; rd_req = 2'b10;
    tick();
    chk_wr("t4.gnt", 2'b01, 1'b0, 1'b1, 2'd1);
    chk_rd("t4.gnt", 2'b10, 1'b1, 1'b1, 2'd1);
    wr_req = 2'b00; rd_req = 2'b00;
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    check("t4.early_r", 32'(rd_state_dbg), 32'd1);
    aw_hs = 1'b1; w_hs = 1'b1; ar_hs = 1'b1;
    tick();
    aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0;
    check("t4.wr_resp", 32'(wr_state_dbg), 32'd2);
    check("t4.rd_data", 32'(rd_state_dbg), 32'd2);
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    chk_rd("t4.rd_done", 2'b00, 1'b0, 1'b0, 2'd0);
    check("t4.wr_still", 32'(wr_busy), 32'd1);
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    chk_wr("t4.wr_done", 2'b00, 1'b0, 1'b0, 2'd0);

    // Read pointer wrapped to 0 after M1 won
    rd_req = 2'b11;
    tick();
    chk_rd("t4.wrap", 2'b01, 1'b0, 1'b1, 2'd1);
    rd_req = 2'b00;
    ar_hs = 1'b1;
    tick();
    ar_hs = 1'b0;
    r_hs = 1'b1;
    tick();
    r_hs = 1'b0;
    check("t4.wrap_done", 32'(rd_busy), 32'd0);

    // Reset in W_RESP with M1 granted aborts and clears the pointer
    wr_req = 2'b11;
    tick();
    chk_wr("t5.gnt", 2'b10, 1'b1, 1'b1, 2'd1);
    aw_hs = 1'b1; w_hs = 1'b1;
    tick();
    aw_hs = 1'b0; w_hs = 1'b0;
    check("t5.resp", 32'(wr_state_dbg), 32'd2);
    aresetn = 1'b0;
    #1;
    chk_wr("t5.async", 2'b00, 1'b0, 1'b0, 2'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    chk_wr("t5.regrant", 2'b01, 1'b0, 1'b1, 2'd1);
    wr_req = 2'b00;
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    check("t5.b_ignored", 32'(wr_state_dbg), 32'd1);
    aw_hs = 1'b1; w_hs = 1'b1;
    tick();
    aw_hs = 1'b0; w_hs = 1'b0;
    b_hs = 1'b1;
    tick();
    b_hs = 1'b0;
    check("t5.done", 32'(wr_busy), 32'd0);
    check("t5.no_timeout", 32'(timeout_err), 32'd0);

`ifdef AXI_ARB_TIMEOUT_EN
    // Watchdog: 16 busy cycles, then forced release with a one-cycle pulse
    wr_req = 2'b01;
    tick();
    check("t6.gnt", 32'(wr_busy), 32'd1);
    wr_req = 2'b00;
    for (int i = 0; i < 15; i++) tick();
    check("t6.busy16", 32'(wr_busy), 32'd1);
    check("t6.no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    check("t6.released", 32'(wr_busy), 32'd0);
    check("t6.err", 32'(timeout_err), 32'd1);
    tick();
    check("t6.err_pulse", 32'(timeout_err), 32'd0);
    wr_req = 2'b01;
    tick();
    chk_wr("t6.regrant", 2'b01, 1'b0, 1'b1, 2'd1);
    wr_req = 2'b00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
